// File: rtl/apb_master_mslave_if.sv
// rtl/apb_master_mslave_if.sv - command, response and APB bus bundle for apb_master_mslave
//
// Purpose: groups the local command port, the response port and the APB
// bus of the bridge.
//   master modport : the bridge's view
//                    (drives cmd_ready, P*, rsp_*, busy)
//   slave modport  : the environment's view
//                    (drives cmd_*, PRDATA, PREADY, PSLVERR)
// Signals:
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata/cmd_strb  command port
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA/PSTRB                     APB request
//   PRDATA/PREADY/PSLVERR                                      per-slave APB reply
//   rsp_valid/rsp_rdata/rsp_err/rsp_timeout                    completion report
//   busy                                                       transfer in progress
interface apb_master_mslave_if #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int NUM_SLAVES = 4
);
  logic                         cmd_valid;
  logic                         cmd_ready;
  logic                         cmd_write;
  logic [ADDR_W-1:0]            cmd_addr;
  logic [DATA_W-1:0]            cmd_wdata;
  logic [DATA_W/8-1:0]          cmd_strb;

  logic [NUM_SLAVES-1:0]        PSEL;
  logic                         PENABLE;
  logic                         PWRITE;
  logic [ADDR_W-1:0]            PADDR;
  logic [DATA_W-1:0]            PWDATA;
  logic [DATA_W/8-1:0]          PSTRB;
  logic [NUM_SLAVES*DATA_W-1:0] PRDATA;
  logic [NUM_SLAVES-1:0]        PREADY;
  logic [NUM_SLAVES-1:0]        PSLVERR;

  logic                         rsp_valid;
  logic [DATA_W-1:0]            rsp_rdata;
  logic                         rsp_err;
  logic                         rsp_timeout;
  logic                         busy;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    output cmd_ready,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    input  cmd_ready,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy
  );
endinterface

// File: rtl/apb_master_mslave.sv
// rtl/apb_master_mslave.sv - APB master bridging a valid/ready command port onto a multi-slave APB bus
//
// Purpose: accepts commands on a valid/ready port, decodes the slave from
// the top address bits and runs SETUP/ACCESS APB transfers. Each transfer
// ends in a one-cycle response pulse that reports slave errors, decode
// errors and wait-state timeouts.
//
// Ports:
//   PCLK    : clock, rising edge
//   PRESET  : synchronous, active-high reset
//   bus     : apb_master_mslave_if.master
//             (command, APB and response signals)
module apb_master_mslave #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int NUM_SLAVES = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  apb_master_mslave_if.master  bus
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int STB_W = DATA_W / 8;
  // The counter only needs to reach TIMEOUT-1; the abort fires while it holds that value.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STB_W-1:0]    strb_q, strb_d;
  logic                write_q, write_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  // A decode error accepted while another response is already going out
  // this cycle; its response is delayed by one cycle.
  logic                pend_q, pend_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                rsp_timeout_q, rsp_timeout_d;

  logic [SEL_W-1:0]    cmd_sel;
  logic                cmd_dec_err;
  logic                pready_sel;
  logic                pslverr_sel;
  logic [DATA_W-1:0]   prdata_sel;
  logic                timing_out;
  logic                cmd_ready;
  logic                accept;
  logic                load;
  logic [NUM_SLAVES-1:0] psel;

  assign cmd_sel     = bus.cmd_addr[ADDR_W-1 -: SEL_W];
  assign cmd_dec_err = (int'(cmd_sel) >= NUM_SLAVES);

  // Reply path of the addressed slave only; other slaves are ignored.
  always_comb begin
    pready_sel  = 1'b0;
    pslverr_sel = 1'b0;
    prdata_sel  = '0;
    psel        = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (int'(sel_q) == i) begin
        pready_sel  = bus.PREADY[i];
        pslverr_sel = bus.PSLVERR[i];
        prdata_sel  = bus.PRDATA[i*DATA_W +: DATA_W];
        psel[i]     = (state_q != S_IDLE);
      end
    end
  end

  assign timing_out = (TIMEOUT != 0) && (state_q == S_ACCESS) && !pready_sel && (cnt_q == CNT_MAX);
  assign cmd_ready  = (state_q == S_IDLE) || ((state_q == S_ACCESS) && pready_sel && !timing_out);
  assign accept     = bus.cmd_valid && cmd_ready;

  assign bus.cmd_ready   = cmd_ready;
  assign bus.PSEL        = psel;
  assign bus.PENABLE     = (state_q == S_ACCESS);
  assign bus.PWRITE      = write_q;
  assign bus.PADDR       = addr_q;
  assign bus.PWDATA      = wdata_q;
  assign bus.PSTRB       = strb_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.busy        = (state_q != S_IDLE);

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    strb_d        = strb_q;
    write_d       = write_q;
    cnt_d         = cnt_q;
    pend_d        = 1'b0;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    load          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = '0;
        end
        if (accept) begin
          if (cmd_dec_err) begin
            // Both responses are identical error reports, so one can wait.
            if (pend_q) begin
              pend_d = 1'b1;
            end else begin
              rsp_valid_d   = 1'b1;
              rsp_err_d     = 1'b1;
              rsp_timeout_d = 1'b0;
              rsp_rdata_d   = '0;
            end
          end else begin
            load    = 1'b1;
            state_d = S_SETUP;
          end
        end
      end

      S_SETUP: begin
        state_d = S_ACCESS;
        cnt_d   = '0;
      end

      S_ACCESS: begin
        if (pready_sel) begin
          rsp_valid_d   = 1'b1;
          rsp_err_d     = pslverr_sel;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = (write_q || pslverr_sel) ? '0 : prdata_sel;
          state_d       = S_IDLE;
          if (accept) begin
            if (cmd_dec_err) begin
              pend_d = 1'b1;
            end else begin
              load    = 1'b1;
              state_d = S_SETUP;
            end
          end
        end else if (timing_out) begin
          state_d       = S_IDLE;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Decode-error commands are not latched so the bus stays quiet.
    if (load) begin
      sel_d   = cmd_sel;
      addr_d  = bus.cmd_addr;
      wdata_d = bus.cmd_wdata;
      write_d = bus.cmd_write;
      strb_d  = bus.cmd_write ? bus.cmd_strb : '0;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q       <= S_IDLE;
      sel_q         <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      strb_q        <= '0;
      write_q       <= 1'b0;
      cnt_q         <= '0;
      pend_q        <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      strb_q        <= strb_d;
      write_q       <= write_d;
      cnt_q         <= cnt_d;
      pend_q        <= pend_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

endmodule
